// File: rtl/sm_regdump.sv
// sm_regdump - register-dump engine for the schoolMIPS debug port.
//
// On a start pulse the engine walks regAddr from REG_FIRST to REG_LAST and
// samples regData once per address. It streams a framed byte sequence on a
// valid/ready interface:
//   0xA5, then for each register {3'b000, addr} followed by 4 data bytes
//   (MSB first), then an optional XOR checksum byte.
//
// Parameters:
//   REG_FIRST  first debug address dumped (address 0 is the PC)
//   REG_LAST   last debug address dumped, REG_FIRST <= REG_LAST <= 31
//   SETTLE     extra wait cycles between driving regAddr and sampling regData (0..15)
//
// Ports:
//   clk       clock (same as cpuClk)
//   rst_n     synchronous active-low reset
//   start     single-cycle dump request, ignored while a dump is running
//   busy      high while a dump is in progress
//   done      one-cycle pulse after the last byte of a frame was accepted
//   regAddr   debug register address to sm_top
//   regData   debug register value from sm_top (combinational from regAddr)
//   tx_data   stream byte
//   tx_valid  tx_data is valid
//   tx_ready  sink accepts the byte
//
// Build option:
//   SM_REGDUMP_CSUM_EN  when defined, a trailing XOR checksum over all address
//                       and data bytes (header excluded) is appended.

module sm_regdump #(
    parameter int unsigned REG_FIRST = 0,
    parameter int unsigned REG_LAST  = 31,
    parameter int unsigned SETTLE    = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [4:0]  regAddr,
    input  logic [31:0] regData,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam logic [4:0] AddrFirst = 5'(REG_FIRST);
    localparam logic [4:0] AddrLast  = 5'(REG_LAST);
    localparam logic [3:0] WaitLast  = 4'((SETTLE == 0) ? 0 : SETTLE - 1);
    localparam logic [7:0] HdrByte   = 8'hA5;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StLoad,
        StWait,
        StAddr,
        StData,
`ifdef SM_REGDUMP_CSUM_EN
        StCsum,
`endif
        StFin
    } stateT;

    stateT       state, stateNext;
    logic [4:0]  addr, addrNext;
    logic [31:0] shadow, shadowNext;
    logic [3:0]  waitCnt, waitNext;
    logic [1:0]  byteCnt, byteNext;
    logic [7:0]  dataByte;

`ifdef SM_REGDUMP_CSUM_EN
    logic [7:0]  csum, csumNext;
`endif

    assign regAddr = addr;

    // byteCnt 0..3 selects shadow[31:24] .. shadow[7:0]
    assign dataByte = shadow[{~byteCnt, 3'b000} +: 8];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= StIdle;
            addr    <= 5'd0;
            shadow  <= 32'd0;
            waitCnt <= 4'd0;
            byteCnt <= 2'd0;
        end else begin
            state   <= stateNext;
            addr    <= addrNext;
            shadow  <= shadowNext;
            waitCnt <= waitNext;
            byteCnt <= byteNext;
        end
    end

    always_comb begin
        stateNext  = state;
        addrNext   = addr;
        shadowNext = shadow;
        waitNext   = waitCnt;
        byteNext   = byteCnt;
        busy       = 1'b0;
        done       = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;

        unique case (state)
            StIdle: begin
                if (start) begin
                    stateNext = StHdr;
                end
            end

            StHdr: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = HdrByte;
                if (tx_ready) begin
                    addrNext  = AddrFirst;
                    stateNext = StLoad;
                end
            end

            // First cycle with regAddr = k; captures here when no settle time is needed.
            StLoad: begin
                busy = 1'b1;
                if (SETTLE == 0) begin
                    shadowNext = regData;
                    stateNext  = StAddr;
                end else begin
                    waitNext  = 4'd0;
                    stateNext = StWait;
                end
            end

            StWait: begin
                busy = 1'b1;
                if (waitCnt == WaitLast) begin
                    shadowNext = regData;
                    stateNext  = StAddr;
                end else begin
                    waitNext = waitCnt + 4'd1;
                end
            end

            StAddr: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = {3'b000, addr};
                if (tx_ready) begin
                    byteNext  = 2'd0;
                    stateNext = StData;
                end
            end

            StData: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = dataByte;
                if (tx_ready) begin
                    if (byteCnt == 2'd3) begin
                        if (addr == AddrLast) begin
`ifdef SM_REGDUMP_CSUM_EN
                            stateNext = StCsum;
`else
                            addrNext  = 5'd0;
                            stateNext = StFin;
`endif
                        end else begin
                            addrNext  = addr + 5'd1;
                            stateNext = StLoad;
                        end
                    end else begin
                        byteNext = byteCnt + 2'd1;
                    end
                end
            end

`ifdef SM_REGDUMP_CSUM_EN
            StCsum: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = csum;
                if (tx_ready) begin
                    addrNext  = 5'd0;
                    stateNext = StFin;
                end
            end
`endif

            // start is deliberately not looked at here: a request coinciding with done is dropped.
            StFin: begin
                done      = 1'b1;
                stateNext = StIdle;
            end

            default: begin
                stateNext = StIdle;
            end
        endcase
    end

`ifdef SM_REGDUMP_CSUM_EN
    always_comb begin
        csumNext = csum;
        if (state == StHdr) begin
            csumNext = 8'h00;
        end else if ((state == StAddr || state == StData) && tx_ready) begin
            csumNext = csum ^ tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            csum <= 8'h00;
        end else begin
            csum <= csumNext;
        end
    end
`endif

endmodule

// File: tb/tb_sm_regdump.sv
`timescale 1ns/1ps

module tb_sm_regdump;

    localparam int First1  = 5;
    localparam int Last1   = 5;
    localparam int Settle1 = 3;
`ifdef SM_REGDUMP_CSUM_EN
    localparam int CsumBytes = 1;
`else
    localparam int CsumBytes = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start0, start1;
    logic        tx_ready;
    logic        busy0, done0, valid0, busy1, done1, valid1;
    logic [4:0]  addr0, addr1;
    logic [31:0] data0, data1;
    logic [7:0]  txd0, txd1;

    logic [31:0] rf   [32];
    logic [31:0] snap [32];
    logic [7:0]  gotQ [$];
    logic [7:0]  expQ [$];

    int errors = 0;
    int checks = 0;
    int sel    = 0;
    int busyCnt, doneCycle, doneCnt;

    logic       obsBusy, obsDone, obsValid;
    logic [7:0] obsData;
    logic [4:0] obsAddr;

    always #5 clk = ~clk;

    // register file seen through each instance's debug port
    assign data0 = rf[addr0];
    assign data1 = rf[addr1];

    sm_regdump u_dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start0),
        .busy     (busy0),
        .done     (done0),
        .regAddr  (addr0),
        .regData  (data0),
        .tx_data  (txd0),
        .tx_valid (valid0),
        .tx_ready (tx_ready)
    );

    sm_regdump #(
        .REG_FIRST (First1),
        .REG_LAST  (Last1),
        .SETTLE    (Settle1)
    ) u_dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start1),
        .busy     (busy1),
        .done     (done1),
        .regAddr  (addr1),
        .regData  (data1),
        .tx_data  (txd1),
        .tx_valid (valid1),
        .tx_ready (tx_ready)
    );

    always_comb begin
        if (sel == 1) begin
            obsBusy = busy1; obsDone = done1; obsValid = valid1; obsData = txd1; obsAddr = addr1;
        end else begin
            obsBusy = busy0; obsDone = done0; obsValid = valid0; obsData = txd0; obsAddr = addr0;
        end
    end

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic setStart(input logic v);
        if (sel == 1) start1 = v;
        else start0 = v;
    endtask

    task automatic checkResetOuts(input string tag);
        checkEq({tag, "_busy0"},  busy0,  0);
        checkEq({tag, "_done0"},  done0,  0);
        checkEq({tag, "_addr0"},  addr0,  0);
        checkEq({tag, "_valid0"}, valid0, 0);
        checkEq({tag, "_data0"},  txd0,   0);
        checkEq({tag, "_busy1"},  busy1,  0);
        checkEq({tag, "_valid1"}, valid1, 0);
        checkEq({tag, "_addr1"},  addr1,  0);
    endtask

    // Reference frame from the register snapshot.
    task automatic buildExp(input int first, input int last);
        logic [7:0] cs;
        cs = 8'h00;
        expQ.delete();
        expQ.push_back(8'hA5);
        for (int k = first; k <= last; k++) begin
            expQ.push_back(8'(k));
            cs ^= 8'(k);
            for (int b = 3; b >= 0; b--) begin
                expQ.push_back(snap[k][8*b +: 8]);
                cs ^= snap[k][8*b +: 8];
            end
        end
`ifdef SM_REGDUMP_CSUM_EN
        expQ.push_back(cs);
`endif
    endtask

    task automatic compareFrame(input string tag);
        int e0;
        checkEq({tag, "_len"}, gotQ.size(), expQ.size());
        for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
            e0 = errors;
            checkEq($sformatf("%s_byte%0d", tag, i), gotQ[i], expQ[i]);
            if (errors != e0) break;
        end
    endtask

    // Start a dump on the selected instance and collect accepted bytes.
    // reA/reB: cycles in which start is pulsed again; mutate: scramble the
    // addressed register every cycle; abortAfter: stop after that many bytes.
    task automatic runFrame(input int readyPct, input int reA, input int reB,
                            input bit mutate, input int abortAfter);
        int         settle, age, stallBad;
        logic       prevStall;
        logic [7:0] prevData;
        logic [4:0] prevAddr;
        settle    = (sel == 1) ? Settle1 : 0;
        gotQ.delete();
        busyCnt   = 0;
        doneCycle = 0;
        doneCnt   = 0;
        stallBad  = 0;
        age       = 0;
        prevStall = 1'b0;
        prevData  = 8'h00;
        prevAddr  = 5'd0;
        for (int i = 0; i < 32; i++) snap[i] = rf[i];
        @(negedge clk);
        setStart(1'b1);
        for (int c = 1; c <= 3000; c++) begin
            @(negedge clk);
            setStart((c == reA) || (c == reB));
            tx_ready = ($urandom_range(99) < readyPct);
            if (mutate && obsBusy) rf[obsAddr] = $urandom;
            if (obsAddr != prevAddr) age = 1;
            else age++;
            prevAddr = obsAddr;
            // value present during cycle SETTLE+1 of an address is the one captured
            if (mutate && obsBusy && age == settle + 1) snap[obsAddr] = rf[obsAddr];
            if (c == 1) begin
                checkEq("start_busy",  obsBusy,  1);
                checkEq("start_valid", obsValid, 1);
                checkEq("start_hdr",   obsData,  8'hA5);
            end
            if (prevStall && (!obsValid || obsData != prevData)) stallBad++;
            if (obsBusy) busyCnt++;
            if (obsDone) begin
                doneCnt++;
                if (doneCycle == 0) doneCycle = c;
            end
            if (obsValid && tx_ready) gotQ.push_back(obsData);
            prevStall = obsValid && !tx_ready;
            prevData  = obsData;
            if (abortAfter > 0 && gotQ.size() == abortAfter) break;
            if (doneCycle != 0 && c >= doneCycle + 8) break;
        end
        setStart(1'b0);
        checkEq("stall_hold", stallBad, 0);
        if (abortAfter == 0) checkEq("done_seen", doneCycle != 0, 1);
    endtask

    initial begin
        int quiet;
        rst_n    = 1'b0;
        start0   = 1'b0;
        start1   = 1'b0;
        tx_ready = 1'b0;
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        rf[0]  = 32'h0040_0024;
        rf[2]  = 32'h1234_5678;
        rf[31] = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        checkResetOuts("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // full dump, no backpressure
        sel = 0;
        runFrame(100, 0, 0, 1'b0, 0);
        buildExp(0, 31);
        compareFrame("full");
        checkEq("full_busy",     busyCnt,   1 + 32 * 6 + CsumBytes);
        checkEq("full_done_cyc", doneCycle, 2 + 32 * 6 + CsumBytes);
        checkEq("full_done_cnt", doneCnt,   1);

        // same contents, 50% backpressure
        runFrame(50, 0, 0, 1'b0, 0);
        buildExp(0, 31);
        compareFrame("bp");
        checkEq("bp_done_cnt", doneCnt, 1);

        // random register contents
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        runFrame(70, 0, 0, 1'b0, 0);
        buildExp(0, 31);
        compareFrame("rand");

        // start re-pulsed while busy
        runFrame(100, 3, 50, 1'b0, 0);
        buildExp(0, 31);
        compareFrame("restart");
        checkEq("restart_busy",     busyCnt,   1 + 32 * 6 + CsumBytes);
        checkEq("restart_done_cyc", doneCycle, 2 + 32 * 6 + CsumBytes);
        checkEq("restart_done_cnt", doneCnt,   1);

        // single register, settle time 3
        sel    = 1;
        rf[5]  = 32'h0000_00FF;
        runFrame(100, 0, 0, 1'b0, 0);
        buildExp(First1, Last1);
        compareFrame("single");
        checkEq("single_busy",     busyCnt,   1 + (6 + Settle1) + CsumBytes);
        checkEq("single_done_cyc", doneCycle, 2 + (6 + Settle1) + CsumBytes);
        checkEq("single_done_cnt", doneCnt,   1);

        // register changing every cycle: only the capture-cycle value may appear
        for (int r = 0; r < 3; r++) begin
            runFrame(50, 0, 0, 1'b1, 0);
            buildExp(First1, Last1);
            compareFrame($sformatf("capture%0d", r));
        end

        // reset in the middle of a frame
        sel = 0;
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        runFrame(100, 0, 0, 1'b0, 20);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkResetOuts("abort_rst1");
        @(negedge clk);
        checkResetOuts("abort_rst2");
        rst_n = 1'b1;
        quiet = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy0 || done0 || valid0 || addr0 != 5'd0) quiet++;
        end
        checkEq("abort_quiet", quiet, 0);
        runFrame(60, 0, 0, 1'b0, 0);
        buildExp(0, 31);
        compareFrame("fresh");
        checkEq("fresh_done_cnt", doneCnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sm_regdump.md
# sm_regdump

Hardware register-dump engine for the schoolMIPS debug port. On a start pulse it sweeps `regAddr` over a configurable register range, samples `regData` for each address, and emits a framed byte stream on a valid/ready interface for a UART transmitter or host link. It is the hardware counterpart of the simulation-only PC/register printout: it sits beside `sm_top` and drives the same `regAddr`/`regData` pair that the board switches and display otherwise use.

## Interface
- `REG_FIRST`, 0, first debug address dumped; address 0 returns the PC.
- `REG_LAST`, 31, last debug address dumped; must satisfy `REG_FIRST <= REG_LAST <= 31`.
- `SETTLE`, 0, extra wait cycles between driving `regAddr` and sampling `regData`; range 0..15.
- `clk`  in  1  single clock; the same clock as the CPU (`cpuClk`).
- `rst_n`  in  1  reset; **synchronous, active-low**.
- `start`  in  1  single-cycle request to begin a dump.
- `busy`  out  1  high while a dump is in progress.
- `done`  out  1  one-cycle pulse after the last byte of a frame has been accepted.
- `regAddr`  out  5  debug register address, driven to `sm_top.regAddr`.
- `regData`  in  32  debug register value, from `sm_top.regData`; combinational from `regAddr`.
- `tx_data`  out  8  stream byte.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  sink accepts the byte.

## Operation
- Frame layout:
  - Header byte 0xA5.
  - For each register k = `REG_FIRST`..`REG_LAST`, in order: one address byte {3'b000, k}, then 4 data bytes, MSB first.
  - Optional checksum byte (see Configuration).
- FSM states: IDLE, HDR, LOAD, WAIT, ADDR, DATA, CSUM, FIN.
- IDLE:
  - `busy` = 0 and `regAddr` = 0, so the PC stays on the debug display.
  - `start` = 1 moves the FSM to HDR.
- HDR: `tx_valid` = 1, `tx_data` = 0xA5. On transfer, `regAddr` is set to `REG_FIRST` and the FSM moves to LOAD.
- LOAD and WAIT:
  - `regAddr` is held stable.
  - LOAD lasts 1 cycle, WAIT lasts `SETTLE` cycles.
  - At the final edge of this period, `regData` is captured into a 32-bit shadow register. The FSM then moves to ADDR.
- ADDR: sends the address byte, then moves to DATA.
- DATA:
  - Sends shadow[31:24], [23:16], [15:8], [7:0], tracked by a 2-bit byte counter.
  - After the last byte: if k < `REG_LAST`, increment `regAddr` and go to LOAD. Otherwise go to CSUM if enabled, else FIN.
- FIN: `done` = 1 for one cycle, `busy` = 0, `regAddr` returns to 0, and the FSM returns to IDLE.
- Handshake rules:
  - A byte transfers on a rising edge where `tx_valid` and `tx_ready` are both 1.
  - While `tx_valid` = 1 and the byte has not transferred, `tx_data` is held stable.
  - `tx_valid` never depends combinationally on `tx_ready`.
  - `tx_valid` = 0 in IDLE, LOAD, WAIT and FIN.
- Boundary conditions:
  - `start` while `busy` = 1 is ignored; it is not queued.
  - `start` in the same cycle as FIN is ignored.
  - `tx_ready` stuck at 0 stalls the FSM indefinitely with the current byte held.
  - Register contents may change during a dump; each register's value is sampled exactly once, at its capture edge.
  - `rst_n` = 0 at any point, including mid-frame, aborts the frame at the next edge. No further bytes or `done` pulse are produced.

## Timing
- Reset values: `busy` 0, `done` 0, `regAddr` 0, `tx_valid` 0, `tx_data` 0x00, FSM in IDLE, shadow 0.
- Latency from start: `start` sampled at edge 0. From cycle 1, `busy` = 1 and `tx_valid` = 1 with 0xA5.
- With `tx_ready` held at 1 and N = `REG_LAST` − `REG_FIRST` + 1:
  - Cycles per register = 6 + `SETTLE`.
  - `busy` duration = 1 + N·(6 + `SETTLE`) [+1 with checksum] cycles.
  - `done` follows in the next cycle.
  - Default configuration: 193 busy cycles (194 with checksum) and 161 frame bytes (162 with checksum).
- Capture edge: the edge ending cycle `SETTLE` + 1, counted from the first cycle `regAddr` = k.

## Configuration
- `SM_REGDUMP_CSUM_EN` defined:
  - An 8-bit running XOR of every address and data byte (header excluded) is kept.
  - It is cleared in HDR and sent as the last byte in state CSUM.
- `SM_REGDUMP_CSUM_EN` undefined:
  - No CSUM state and no checksum logic.
  - The frame ends after the last data byte.

## Test plan
- Full dump, defaults, `tx_ready` = 1:
  - Preload rf[2] = 0x12345678, rf[31] = 0xDEADBEEF, all others 0.
  - Expected: 161 bytes starting A5 00 {PC bytes} 01 00 00 00 00 02 12 34 56 78 …, ending 1F DE AD BE EF.
  - Expected: `done` in cycle 194.
- Backpressure: `tx_ready` toggled pseudo-randomly at 50%. The byte sequence must be identical to the first scenario, and `tx_data` must never change while stalled.
- Single register: `REG_FIRST` = `REG_LAST` = 5, rf[5] = 0x000000FF, `SETTLE` = 3.
  - Expected frame: A5 05 00 00 00 FF.
  - Expected: capture 4 cycles after `regAddr` = 5, and `busy` lasting 10 cycles.
- `start` re-pulsed at cycles 3 and 50 of a running dump: no restart, and exactly one `done`.
- Reset mid-frame: assert `rst_n` = 0 for 2 cycles after the 20th byte. All outputs go to their reset values; a new `start` yields a complete, fresh frame.
- With `SM_REGDUMP_CSUM_EN`, `REG_FIRST` = `REG_LAST` = 2, rf[2] = 0x12345678:
  - Expected frame: A5 02 12 34 56 78 0A (0x02^0x12^0x34^0x56^0x78 = 0x0A).
